// File: rtl/day_of_month.sv
// Day-of-month counter: counts 1..last-day-of-month on a day tick and emits month_tick on wrap.
// Supports a validated synchronous date load and drives a gated databus for the display mux.
module day_of_month #(
    parameter int unsigned RESET_DAY = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       tick,
    input  logic       load,
    input  logic [4:0] data,
    input  logic [3:0] month,
    input  logic       leap,
    input  logic       enable,
    output logic [4:0] day,
    output logic       month_tick,
    output logic       load_err,
    output logic [4:0] databus
);

    localparam int unsigned DW = 5;

    logic [DW-1:0] last;
    logic [DW-1:0] day_next;
    logic          month_tick_next;
    logic          load_err_next;
    logic          load_ok;

    // Last legal day of the current month; illegal months fall back to 31.
    always_comb begin
        last = DW'(31);
        unique case (month)
            4'd2:                      last = leap ? DW'(29) : DW'(28);
            4'd4, 4'd6, 4'd9, 4'd11:   last = DW'(30);
            default:                   last = DW'(31);
        endcase
    end

    assign load_ok = (data >= DW'(1)) && (data <= last);

    // Priority load > tick > hold; a tick coincident with a load is dropped.
    always_comb begin
        day_next        = day;
        month_tick_next = 1'b0;
        load_err_next   = 1'b0;
        if (load) begin
            if (load_ok) begin
                day_next = data;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (tick) begin
            // >= so a day carried over from a longer month still wraps.
            if (day >= last) begin
                day_next        = DW'(1);
                month_tick_next = 1'b1;
            end else begin
                day_next = day + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            day        <= DW'(RESET_DAY);
            month_tick <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            day        <= day_next;
            month_tick <= month_tick_next;
            load_err   <= load_err_next;
        end
    end

    assign databus = day & {DW{enable}};

endmodule

// File: tb/tb_day_of_month.sv
// Self-checking bench for day_of_month: directed steps with a scoreboard queue of expected outputs.
module tb_day_of_month;

    typedef struct packed {
        logic [4:0] day;
        logic       mt;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear;
    logic       tick;
    logic       load;
    logic [4:0] data;
    logic [3:0] month;
    logic       leap;
    logic       enable;
    logic [4:0] day;
    logic       month_tick;
    logic       load_err;
    logic [4:0] databus;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [4:0] m_day;

    day_of_month #(.RESET_DAY(1)) dut (
        .clk        (clk),
        .clear      (clear),
        .tick       (tick),
        .load       (load),
        .data       (data),
        .month      (month),
        .leap       (leap),
        .enable     (enable),
        .day        (day),
        .month_tick (month_tick),
        .load_err   (load_err),
        .databus    (databus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] last_of(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                    return lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, push the model's expectation, then pop and compare after the edge.
    task automatic step(input string tag, input logic t, input logic l, input logic [4:0] d);
        exp_t e;
        logic [4:0] lastv;
        @(negedge clk);
        tick = t;
        load = l;
        data = d;
        lastv = last_of(month, leap);
        e.mt  = 1'b0;
        e.err = 1'b0;
        if (l) begin
            if (d >= 5'd1 && d <= lastv) m_day = d;
            else e.err = 1'b1;
        end else if (t) begin
            if (m_day >= lastv) begin
                m_day = 5'd1;
                e.mt  = 1'b1;
            end else begin
                m_day = m_day + 5'd1;
            end
        end
        e.day = m_day;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".day"}, int'(day), int'(e.day));
        check({tag, ".month_tick"}, int'(month_tick), int'(e.mt));
        check({tag, ".load_err"}, int'(load_err), int'(e.err));
        tick = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        clear  = 1'b1;
        tick   = 1'b0;
        load   = 1'b0;
        data   = 5'd0;
        month  = 4'd1;
        leap   = 1'b0;
        enable = 1'b0;
        m_day  = 5'd1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.day", int'(day), 1);
        check("reset.month_tick", int'(month_tick), 0);
        check("reset.load_err", int'(load_err), 0);
        check("reset.databus", int'(databus), 0);
        @(negedge clk);
        clear = 1'b0;

        // Asynchronous clear mid-count at day 17
        step("load17", 1'b0, 1'b1, 5'd17);
        check("pre_clear.day", int'(day), 17);
        @(negedge clk);
        #2;
        clear = 1'b1;
        #1;
        check("async_clear.day", int'(day), 1);
        check("async_clear.month_tick", int'(month_tick), 0);
        check("async_clear.load_err", int'(load_err), 0);
        @(negedge clk);
        clear = 1'b0;
        m_day = 5'd1;

        // 30-day month wrap
        month = 4'd4;
        step("apr.load29", 1'b0, 1'b1, 5'd29);
        step("apr.tick30", 1'b1, 1'b0, 5'd0);
        step("apr.wrap", 1'b1, 1'b0, 5'd0);
        check("apr.wrap_const", int'(month_tick), 1);
        step("apr.idle", 1'b0, 1'b0, 5'd0);

        // 31-day month wrap
        month = 4'd1;
        step("jan.load30", 1'b0, 1'b1, 5'd30);
        step("jan.tick31", 1'b1, 1'b0, 5'd0);
        check("jan.day31_const", int'(day), 31);
        step("jan.wrap", 1'b1, 1'b0, 5'd0);
        step("jan.idle", 1'b0, 1'b0, 5'd0);

        // February, non-leap and leap
        month = 4'd2;
        leap  = 1'b0;
        step("feb.load28", 1'b0, 1'b1, 5'd28);
        step("feb.wrap", 1'b1, 1'b0, 5'd0);
        check("feb.wrap_const", int'(day), 1);
        leap = 1'b1;
        step("feb_leap.load28", 1'b0, 1'b1, 5'd28);
        step("feb_leap.tick29", 1'b1, 1'b0, 5'd0);
        check("feb_leap.no_mt_const", int'(month_tick), 0);
        step("feb_leap.wrap", 1'b1, 1'b0, 5'd0);

        // Load validation
        leap = 1'b0;
        step("lv.load10", 1'b0, 1'b1, 5'd10);
        step("lv.reject29", 1'b0, 1'b1, 5'd29);
        check("lv.reject29_const", int'(load_err), 1);
        step("lv.err_drop", 1'b0, 1'b0, 5'd0);
        step("lv.reject0", 1'b0, 1'b1, 5'd0);
        step("lv.load15", 1'b0, 1'b1, 5'd15);
        check("lv.load15_const", int'(day), 15);

        // Simultaneous load and tick: tick is dropped
        month = 4'd3;
        step("sim.load_tick", 1'b1, 1'b1, 5'd10);
        check("sim.load_tick_const", int'(day), 10);

        // Clear during load
        @(negedge clk);
        load  = 1'b1;
        data  = 5'd20;
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clear_load.day", int'(day), 1);
        check("clear_load.load_err", int'(load_err), 0);
        @(negedge clk);
        clear = 1'b0;
        load  = 1'b0;
        m_day = 5'd1;

        // Over-range carry into a shorter month
        month = 4'd1;
        step("ovr.load31", 1'b0, 1'b1, 5'd31);
        month = 4'd6;
        step("ovr.hold", 1'b0, 1'b0, 5'd0);
        check("ovr.hold_const", int'(day), 31);
        step("ovr.wrap", 1'b1, 1'b0, 5'd0);

        // Databus gating
        month = 4'd5;
        step("bus.load23", 1'b0, 1'b1, 5'd23);
        enable = 1'b0;
        #1;
        check("bus.disabled", int'(databus), 0);
        enable = 1'b1;
        #1;
        check("bus.enabled", int'(databus), 23);

        // Random mix, including illegal months
        for (int i = 0; i < 60; i++) begin
            month = 4'($urandom_range(0, 15));
            leap  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0)
                step("rnd", 1'b0, 1'b1, 5'($urandom_range(0, 31)));
            else
                step("rnd", 1'($urandom_range(0, 3) != 0), 1'b0, 5'd0);
            check("rnd.databus", int'(databus), int'(m_day));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
